// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction ROM bus and the
// IF/ID register, with delay-slot redirects, stalled-redirect memory and flushes.
module inst_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] ibus_addr,
  output logic        ibus_read,
  input  logic [31:0] ibus_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel
);

  logic [31:0] pc_r;
  logic        pend_valid_r;
  logic [31:0] pend_target_r;

  logic        fire_s;
  logic        misal_s;
  logic [31:0] next_pc_s;

  // Fetch enable, alignment check and next-PC selection.
  always_comb begin
    fire_s  = !rst && !flush && (!id_valid || id_ready);
    misal_s = (pc_r[1:0] != 2'b00);
    // A live redirect beats a remembered one; the remembered one beats sequential.
    if (redirect_valid) begin
      next_pc_s = redirect_target;
    end else if (pend_valid_r) begin
      next_pc_s = pend_target_r;
    end else begin
      next_pc_s = pc_r + 32'd4;
    end
  end

  assign ibus_addr = pc_r;
  assign ibus_read = fire_s && !misal_s;

  // PC, IF/ID register and pending-redirect state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_VECTOR;
      id_valid      <= 1'b0;
      id_pc         <= 32'd0;
      id_inst       <= 32'd0;
      id_adel       <= 1'b0;
      pend_valid_r  <= 1'b0;
      pend_target_r <= 32'd0;
    end else if (flush) begin
      pc_r         <= flush_target;
      id_valid     <= 1'b0;
      id_adel      <= 1'b0;
      pend_valid_r <= 1'b0;
    end else if (fire_s) begin
      // The word fetched here is the delay slot when a redirect is present.
      id_valid     <= 1'b1;
      id_pc        <= pc_r;
      id_inst      <= misal_s ? 32'd0 : ibus_data;
      id_adel      <= misal_s;
      pc_r         <= next_pc_s;
      pend_valid_r <= 1'b0;
    end else if (redirect_valid) begin
      // Decode is stalled: the held PC becomes the delay slot, target comes after.
      pend_valid_r  <= 1'b1;
      pend_target_r <= redirect_target;
    end else begin
      pend_valid_r  <= pend_valid_r;
      pend_target_r <= pend_target_r;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table for the documented scenarios,
// then randomized traffic against a behavioural reference model.
module tb_inst_fetch;

  localparam logic [31:0] RV = 32'hbfc00000;

  logic        clk;
  logic        rst;
  logic [31:0] ibus_addr;
  logic        ibus_read;
  logic [31:0] ibus_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        flush;
  logic [31:0] flush_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;

  int checks;
  int errors;

  inst_fetch #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst(rst),
    .ibus_addr(ibus_addr), .ibus_read(ibus_read), .ibus_data(ibus_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .flush(flush), .flush_target(flush_target),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst), .id_adel(id_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h0badcafe;
  endfunction

  // ROM returns 0 when not strobed
  assign ibus_data = ibus_read ? rom_word(ibus_addr) : 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        ready;
    logic        redir;
    logic [31:0] redir_tgt;
    logic        flush;
    logic [31:0] flush_tgt;
    logic        exp_read;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_adel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rt,
                     input logic fl, input logic [31:0] ft, input logic er, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ep, input logic ead);
    vec_t v;
    v.rst = r; v.ready = rdy; v.redir = rv; v.redir_tgt = rt; v.flush = fl; v.flush_tgt = ft;
    v.exp_read = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep; v.exp_adel = ead;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rt,
                       input logic fl, input logic [31:0] ft);
    rst = r; id_ready = rdy; redirect_valid = rv; redirect_target = rt;
    flush = fl; flush_target = ft;
  endtask

  // Reference model state: architectural view of the fetch stage
  logic [31:0] m_pc, m_idpc, m_inst, m_ptgt;
  logic        m_valid, m_adel, m_pend;

  task automatic model_step();
    if (rst) begin
      m_pc = RV; m_valid = 1'b0; m_idpc = 32'd0; m_inst = 32'd0; m_adel = 1'b0;
      m_pend = 1'b0; m_ptgt = 32'd0;
    end else if (flush) begin
      m_pc = flush_target; m_valid = 1'b0; m_adel = 1'b0; m_pend = 1'b0;
    end else if (!m_valid || id_ready) begin
      m_valid = 1'b1;
      m_idpc  = m_pc;
      m_adel  = (m_pc % 32'd4) != 32'd0;
      m_inst  = m_adel ? 32'd0 : rom_word(m_pc);
      if (redirect_valid) m_pc = redirect_target;
      else if (m_pend)    m_pc = m_ptgt;
      else                m_pc = m_pc + 32'd4;
      m_pend = 1'b0;
    end else if (redirect_valid) begin
      m_pend = 1'b1; m_ptgt = redirect_target;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_inst", id_inst, 32'd0);
    chk("rst_adel", {31'd0, id_adel}, 32'd0);
    chk("rst_read", {31'd0, ibus_read}, 32'd0);
    chk("rst_addr", ibus_addr, RV);

    //   rst   rdy   redir tgt           flush ftgt          rd    addr          vld   pc            adel
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 32'hbfc00000, 1'b1, 32'hbfc00000, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 32'hbfc00004, 1'b1, 32'hbfc00004, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 32'd0,        1'b0, 32'hbfc00008, 1'b1, 32'hbfc00004, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 32'd0,        1'b0, 32'hbfc00008, 1'b1, 32'hbfc00004, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 32'd0,        1'b0, 32'hbfc00008, 1'b1, 32'hbfc00004, 1'b0);
    add(1'b0, 1'b1, 1'b1, 32'hbfc00100, 1'b0, 32'd0,        1'b1, 32'hbfc00008, 1'b1, 32'hbfc00008, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 32'hbfc00100, 1'b1, 32'hbfc00100, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 32'hbfc00104, 1'b1, 32'hbfc00104, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b1, 32'hbfc00008, 1'b0, 32'hbfc00108, 1'b0, 32'd0,        1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 32'hbfc00008, 1'b1, 32'hbfc00008, 1'b0);
    add(1'b0, 1'b0, 1'b1, 32'hbfc00200, 1'b0, 32'd0,        1'b0, 32'hbfc0000c, 1'b1, 32'hbfc00008, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 32'd0,        1'b0, 32'hbfc0000c, 1'b1, 32'hbfc00008, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 32'hbfc0000c, 1'b1, 32'hbfc0000c, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 32'hbfc00200, 1'b1, 32'hbfc00200, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b1, 32'hbfc00008, 1'b0, 32'hbfc00204, 1'b0, 32'd0,        1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 32'hbfc00008, 1'b1, 32'hbfc00008, 1'b0);
    add(1'b0, 1'b0, 1'b1, 32'hbfc00200, 1'b0, 32'd0,        1'b0, 32'hbfc0000c, 1'b1, 32'hbfc00008, 1'b0);
    add(1'b0, 1'b0, 1'b1, 32'hbfc00300, 1'b0, 32'd0,        1'b0, 32'hbfc0000c, 1'b1, 32'hbfc00008, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 32'hbfc0000c, 1'b1, 32'hbfc0000c, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 32'hbfc00300, 1'b1, 32'hbfc00300, 1'b0);
    add(1'b0, 1'b0, 1'b1, 32'hbfc00400, 1'b0, 32'd0,        1'b0, 32'hbfc00304, 1'b1, 32'hbfc00300, 1'b0);
    add(1'b0, 1'b1, 1'b1, 32'hbfc00500, 1'b1, 32'hbfc00380, 1'b0, 32'hbfc00304, 1'b0, 32'd0,        1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 32'hbfc00380, 1'b1, 32'hbfc00380, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 32'hbfc00384, 1'b1, 32'hbfc00384, 1'b0);
    add(1'b0, 1'b1, 1'b1, 32'hbfc00102, 1'b0, 32'd0,        1'b1, 32'hbfc00388, 1'b1, 32'hbfc00388, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 32'd0,        1'b0, 32'hbfc00102, 1'b1, 32'hbfc00102, 1'b1);
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 32'd0,        1'b0, 32'hbfc00106, 1'b1, 32'hbfc00106, 1'b1);
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b1, 32'hfffffffc, 1'b0, 32'hbfc0010a, 1'b0, 32'd0,        1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 32'hfffffffc, 1'b1, 32'hfffffffc, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 32'h00000000, 1'b1, 32'h00000000, 1'b0);
    add(1'b1, 1'b1, 1'b1, 32'h00001000, 1'b1, 32'h00002000, 1'b0, 32'h00000004, 1'b0, 32'd0,        1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 32'hbfc00000, 1'b1, 32'hbfc00000, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ready, vecs[i].redir, vecs[i].redir_tgt,
            vecs[i].flush, vecs[i].flush_tgt);
      #1;
      chk($sformatf("row%0d_read", i), {31'd0, ibus_read}, {31'd0, vecs[i].exp_read});
      chk($sformatf("row%0d_addr", i), ibus_addr, vecs[i].exp_addr);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid || vecs[i].rst) begin
        chk($sformatf("row%0d_pc", i), id_pc, vecs[i].exp_pc);
        chk($sformatf("row%0d_adel", i), {31'd0, id_adel}, {31'd0, vecs[i].exp_adel});
        chk($sformatf("row%0d_inst", i), id_inst,
            (vecs[i].rst || vecs[i].exp_adel) ? 32'd0 : rom_word(vecs[i].exp_pc));
      end else begin
        chk($sformatf("row%0d_adel", i), {31'd0, id_adel}, 32'd0);
      end
    end

    // Randomized traffic; start from a reset so the model is in sync
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(posedge clk);
    model_step();
    #1;
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] rt, ft;
      rt = RV + ($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 15) == 0) rt = rt | 32'($urandom_range(1, 3));
      ft = RV + ($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 31) == 0) ft = 32'hfffffff8;
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 5) == 0, rt, $urandom_range(0, 19) == 0, ft);
      #1;
      chk("rnd_read", {31'd0, ibus_read},
          {31'd0, !rst && !flush && (!m_valid || id_ready) && (m_pc % 32'd4 == 32'd0)});
      chk("rnd_addr", ibus_addr, m_pc);
      @(posedge clk);
      model_step();
      #1;
      chk("rnd_valid", {31'd0, id_valid}, {31'd0, m_valid});
      chk("rnd_pc", id_pc, m_idpc);
      chk("rnd_inst", id_inst, m_inst);
      chk("rnd_adel", {31'd0, id_adel}, {31'd0, m_adel});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
